// File: rtl/rbm_loop_seq.sv
// RBM training/prediction loop sequencer: walks epochs x users with a read/write
// handshake per user, then one predict pass over test users. Optional macro: RBM_SEQ_ERR_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for conf_done, counts latched on acceptance
// TRAIN_RD | training read request outstanding
// TRAIN_WR | training write request outstanding
// PRED_RD  | predict read request outstanding
// PRED_WR  | predict write request outstanding
// DONE     | one-cycle completion pulse
// ERR      | zero-count configuration, held until rst (RBM_SEQ_ERR_EN only)
module rbm_loop_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_done,
  input  logic [31:0] conf_num_loops,
  input  logic [31:0] conf_num_users,
  input  logic [31:0] conf_num_testusers,
  input  logic        rd_grant,
  input  logic        wr_grant,
  output logic        rd_request,
  output logic        wr_request,
  output logic [1:0]  phase,
  output logic [31:0] user_idx,
  output logic [31:0] loop_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef RBM_SEQ_ERR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_TRAIN_RD, S_TRAIN_WR, S_PRED_RD, S_PRED_WR, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_TRAIN_RD, S_TRAIN_WR, S_PRED_RD, S_PRED_WR, S_DONE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] user_q, user_d;
  logic [31:0] loop_q, loop_d;
  logic [31:0] loops_q, loops_d;
  logic [31:0] users_q, users_d;
  logic [31:0] tusers_q, tusers_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      user_q   <= '0;
      loop_q   <= '0;
      loops_q  <= '0;
      users_q  <= '0;
      tusers_q <= '0;
    end else begin
      state_q  <= state_d;
      user_q   <= user_d;
      loop_q   <= loop_d;
      loops_q  <= loops_d;
      users_q  <= users_d;
      tusers_q <= tusers_d;
    end
  end

  // Comparisons run against count-1 before incrementing, so a count of
  // 0xFFFFFFFF never wraps the index.
  always_comb begin
    state_d  = state_q;
    user_d   = user_q;
    loop_d   = loop_q;
    loops_d  = loops_q;
    users_d  = users_q;
    tusers_d = tusers_q;
    case (state_q)
      S_IDLE: begin
        if (conf_done) begin
          user_d   = '0;
          loop_d   = '0;
          tusers_d = conf_num_testusers;
`ifdef RBM_SEQ_ERR_EN
          loops_d  = conf_num_loops;
          users_d  = conf_num_users;
          if (conf_num_loops == 32'd0 || conf_num_users == 32'd0)
            state_d = S_ERR;
          else
            state_d = S_TRAIN_RD;
`else
          loops_d  = (conf_num_loops == 32'd0) ? 32'd1 : conf_num_loops;
          users_d  = (conf_num_users == 32'd0) ? 32'd1 : conf_num_users;
          state_d  = S_TRAIN_RD;
`endif
        end
      end
      S_TRAIN_RD: begin
        if (rd_grant) state_d = S_TRAIN_WR;
      end
      S_TRAIN_WR: begin
        if (wr_grant) begin
          if (user_q < users_q - 32'd1) begin
            user_d  = user_q + 32'd1;
            state_d = S_TRAIN_RD;
          end else begin
            user_d = '0;
            if (loop_q < loops_q - 32'd1) begin
              loop_d  = loop_q + 32'd1;
              state_d = S_TRAIN_RD;
            end else if (tusers_q == 32'd0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_PRED_RD;
            end
          end
        end
      end
      S_PRED_RD: begin
        if (rd_grant) state_d = S_PRED_WR;
      end
      S_PRED_WR: begin
        if (wr_grant) begin
          if (user_q < tusers_q - 32'd1) begin
            user_d  = user_q + 32'd1;
            state_d = S_PRED_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef RBM_SEQ_ERR_EN
      S_ERR:  state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_request = 1'b0;
    wr_request = 1'b0;
    phase      = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_TRAIN_RD: begin rd_request = 1'b1; phase = 2'd1; busy = 1'b1; end
      S_TRAIN_WR: begin wr_request = 1'b1; phase = 2'd1; busy = 1'b1; end
      S_PRED_RD:  begin rd_request = 1'b1; phase = 2'd2; busy = 1'b1; end
      S_PRED_WR:  begin wr_request = 1'b1; phase = 2'd2; busy = 1'b1; end
      S_DONE:     begin done = 1'b1; phase = 2'd3; busy = 1'b1; end
`ifdef RBM_SEQ_ERR_EN
      S_ERR:      phase = 2'd3;
`endif
      default: ;
    endcase
  end

`ifdef RBM_SEQ_ERR_EN
  assign err = (state_q == S_ERR);
`else
  assign err = 1'b0;
`endif

  assign user_idx = user_q;
  assign loop_idx = loop_q;

endmodule

// File: tb/tb_rbm_loop_seq.sv
// Scoreboard bench for rbm_loop_seq: directed sequences push expected handshakes,
// a negedge monitor pops and compares them.
module tb_rbm_loop_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        conf_done;
  logic [31:0] conf_num_loops, conf_num_users, conf_num_testusers;
  logic        rd_grant, wr_grant;
  logic        rd_request, wr_request;
  logic [1:0]  phase;
  logic [31:0] user_idx, loop_idx;
  logic        busy, done, err;

  rbm_loop_seq dut (
    .clk(clk), .rst(rst), .conf_done(conf_done),
    .conf_num_loops(conf_num_loops), .conf_num_users(conf_num_users),
    .conf_num_testusers(conf_num_testusers),
    .rd_grant(rd_grant), .wr_grant(wr_grant),
    .rd_request(rd_request), .wr_request(wr_request),
    .phase(phase), .user_idx(user_idx), .loop_idx(loop_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 done
    int          ph;
    int unsigned usr;
    int unsigned lp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   tie = 1'b1;
  int   rd_delay = 1;
  int   rd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_request) rd_cnt++;
      else rd_cnt = 0;
      if (tie) begin
        rd_grant = 1'b1;
        wr_grant = 1'b1;
      end else begin
        rd_grant = rd_request && (rd_cnt >= rd_delay);
        wr_grant = wr_request;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected handshake list: train epochs x users, then predict with loop_idx
  // frozen at the last epoch; zero loops/users run as one.
  task automatic push_seq(input int unsigned loops, input int unsigned users,
                          input int unsigned tusers);
    int unsigned el, eu;
    el = (loops == 0) ? 1 : loops;
    eu = (users == 0) ? 1 : users;
    for (int unsigned l = 0; l < el; l++)
      for (int unsigned u = 0; u < eu; u++) begin
        exp_q.push_back('{0, 1, u, l});
        exp_q.push_back('{1, 1, u, l});
      end
    for (int unsigned u = 0; u < tusers; u++) begin
      exp_q.push_back('{0, 2, u, el - 1});
      exp_q.push_back('{1, 2, u, el - 1});
    end
    exp_q.push_back('{2, 3, 0, 0});
  endtask

  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("req_exclusive", rd_request && wr_request, 0);
      mon_kind = -1;
      if (rd_request && rd_grant) mon_kind = 0;
      else if (wr_request && wr_grant) mon_kind = 1;
      else if (done) mon_kind = 2;
      if (mon_kind >= 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual_kind=%0d required=none (t=%0t)", mon_kind, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_kind", mon_kind, mon_e.kind);
          check("sb_phase", phase, mon_e.ph);
          if (mon_kind != 2) begin
            check("sb_user_idx", user_idx, mon_e.usr);
            check("sb_loop_idx", loop_idx, mon_e.lp);
          end
        end
      end
    end
  end

  task automatic start(input logic [31:0] l, input logic [31:0] u, input logic [31:0] t);
    @(posedge clk);
    #1;
    conf_num_loops     = l;
    conf_num_users     = u;
    conf_num_testusers = t;
    conf_done          = 1'b1;
    @(posedge clk);
    #1;
    conf_done = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", max_cyc);
    end
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    check({name, "_phase_idle"}, phase, 0);
    check({name, "_busy_idle"}, busy, 0);
    check({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_req"}, rd_request, 0);
    check({name, "_wr_req"}, wr_request, 0);
    check({name, "_phase"}, phase, 0);
    check({name, "_user_idx"}, user_idx, 0);
    check({name, "_loop_idx"}, loop_idx, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_err"}, err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  bit seen;
  initial begin
    rst = 1'b1;
    conf_done = 1'b0;
    conf_num_loops = 0;
    conf_num_users = 0;
    conf_num_testusers = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Grants tied high: 6 train pairs, 1 predict pair, done 14 cycles in.
    tie = 1'b1;
    push_seq(2, 3, 1);
    start(2, 3, 1);
    wait_done(100, seen);
    if (seen) check("t1_done_latency", cyc - start_cyc, 14);
    check_idle_after("t1");

    // Delayed read grant, no test users.
    tie = 1'b0;
    rd_delay = 5;
    push_seq(1, 1, 0);
    start(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_rd_held", rd_request, 1);
      check("t2_no_wr_while_rd", wr_request, 0);
    end
    @(negedge clk);
    check("t2_rd_released", rd_request, 0);
    check("t2_wr_after_grant", wr_request, 1);
    wait_done(20, seen);
    check_idle_after("t2");

    // Reset during training write in the second epoch, then restart.
    tie = 1'b1;
    rd_delay = 1;
    push_seq(2, 3, 1);
    start(2, 3, 1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_request && loop_idx == 1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t3_reached_wr_loop1", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t3_mid_reset");
    exp_q.delete();
    rst = 1'b0;
    push_seq(1, 2, 0);
    start(1, 2, 0);
    wait_done(50, seen);
    check_idle_after("t3_restart");

    // conf_* changes and a stray conf_done mid-sequence are ignored.
    push_seq(2, 3, 2);
    start(2, 3, 2);
    repeat (3) @(posedge clk);
    #1;
    conf_num_users = 5;
    conf_num_loops = 7;
    conf_done = 1'b1;
    @(posedge clk);
    #1 conf_done = 1'b0;
    wait_done(100, seen);
    check_idle_after("t4");

    // Zero loop count.
`ifdef RBM_SEQ_ERR_EN
    start(0, 2, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_err", err, 1);
      check("t5_phase", phase, 3);
      check("t5_rd_req", rd_request, 0);
      check("t5_wr_req", wr_request, 0);
      check("t5_busy", busy, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_reset");
    rst = 1'b0;
`else
    push_seq(0, 2, 1);
    start(0, 2, 1);
    wait_done(50, seen);
    if (seen) check("t5_done_latency", cyc - start_cyc, 6);
    check("t5_err_tied", err, 0);
    check_idle_after("t5");
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
